rom_burst_arbiter: RTL

Round-robin arbiter sharing the single synchronous read port of the init-file ROM among three requesters (r0, r1, r2). A granted requester receives one non-preemptive burst of DATA_AMOUNT ROM words on a common output bus, tagged with its ID. The block sits in the clk1 domain between the ROM and the downstream consumers feeding the top-level output path, gated by the top-level start.

---
 rtl/rom_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 26 ++
 rtl/rom_burst_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types for the ROM burst arbiter
package rom_arb_pkg;

    localparam int NUM_REQ = 3;

    typedef logic [1:0] req_id_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select, searching upward from last+1
module rr_picker
    import rom_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            last,
    output req_id_t            winner,
    output logic               valid
);

    req_id_t idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = req_id_t'((int'(last) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin arbiter granting non-preemptive ROM read bursts
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int DATA_AMOUNT = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk1,
    input  logic                  reset,
    input  logic                  top_start,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [1:0]            out_id,
    output logic                  burst_done,
    output logic                  busy
);

    localparam int BEAT_W = $clog2(DATA_AMOUNT + 1);
    localparam bit DEPTH_POW2 = ((DEPTH & (DEPTH - 1)) == 0);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_AMOUNT - 1);

    state_t                state;
    state_t                next_state;
    logic [BEAT_W-1:0]     beat;
    logic [ADDR_WIDTH-1:0] addr;
    req_id_t               last;
    req_id_t               owner;
    req_id_t               winner;
    logic                  win_valid;
    logic                  start_burst;
    logic                  rom_en_q;

    rr_picker u_picker (
        .req    (req),
        .last   (last),
        .winner (winner),
        .valid  (win_valid)
    );

    assign start_burst = (state == IDLE) && top_start && win_valid;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state    <= IDLE;
            beat     <= '0;
            last     <= 2'd2;
            owner    <= '0;
            rom_en_q <= 1'b0;
        end else begin
            state    <= next_state;
            rom_en_q <= rom_en;
            if (start_burst) begin
                beat  <= '0;
                owner <= winner;
            end else if (state == READ) begin
                beat <= beat + 1'b1;
            end
            if (state == DRAIN) begin
                last <= owner;
            end
        end
    end

    // Non-power-of-two depths cannot wrap by truncation, so they get their own modulo counter.
    generate
        if (DEPTH_POW2) begin : g_addr_slice
            assign addr = ADDR_WIDTH'(beat);
        end else begin : g_addr_wrap
            logic [ADDR_WIDTH-1:0] addr_q;
            always_ff @(posedge clk1) begin
                if (reset || start_burst) begin
                    addr_q <= '0;
                end else if (state == READ) begin
                    addr_q <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                end
            end
            assign addr = addr_q;
        end
    endgenerate

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_burst) next_state = READ;
            READ:    if (beat == LAST_BEAT) next_state = DRAIN;
            DRAIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rom_en     = (state == READ);
        rom_addr   = rom_en ? addr : '0;
        busy       = (state != IDLE);
        burst_done = (state == DRAIN);
        grant      = busy ? (NUM_REQ'(1) << owner) : '0;
        out_id     = owner;
        out_valid  = rom_en_q;
        out_data   = rom_data;
    end

endmodule
